// File: rtl/aes128_cbc.sv
// Bit-serial AES-128 CBC encryptor: shifts plaintext/key/IV in MSB first,
// then runs one AES round per clock and presents the ciphertext in parallel.
module aes128_cbc (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_inp,
    input  logic         s_key,
    input  logic         s_init_v,
    output logic [127:0] out,
    output logic         flag_sinp
);

    // flag_sinp protocol: it rises on the edge that samples the 128th serial
    // bit and falls on the edge that writes out; that falling edge is the
    // only "valid" strobe, and out holds its value between strobes.
    typedef enum logic [1:0] {LOAD, INIT, ROUND} state_t;

    state_t         state, state_nx;
    logic [6:0]     cnt;
    logic [3:0]     rnd;
    logic           first_block;
    logic [127:0]   data_sr, key_sr, iv_sr;
    logic [127:0]   st, rk;
    logic           load_done, last_round;

    logic [127:0]   sb, sr, mc, rnd_out, rk_n;
    logic [31:0]    kt, n0, n1, n2, n3;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (zero maps to zero naturally).
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x3, x7, x15, x31, x63, x127;
        x3   = gf_mul(gf_mul(a, a), a);
        x7   = gf_mul(gf_mul(x3, x3), a);
        x15  = gf_mul(gf_mul(x7, x7), a);
        x31  = gf_mul(gf_mul(x15, x15), a);
        x63  = gf_mul(gf_mul(x31, x31), a);
        x127 = gf_mul(gf_mul(x63, x63), a);
        return gf_mul(x127, x127);
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = gf_inv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Round datapath: byte i of the state lives at bits [127-8i -: 8],
    // bytes are column-major (byte 4c+r is row r of column c).
    always_comb begin
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) begin
            sb[127-8*i -: 8] = sbox(st[127-8*i -: 8]);
        end
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        for (int c = 0; c < 4; c++) begin
            mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
        end
    end

    always_comb begin
        kt   = sub_word({rk[23:0], rk[31:24]}) ^ {rcon(rnd), 24'h000000};
        n0   = rk[127:96] ^ kt;
        n1   = rk[95:64]  ^ n0;
        n2   = rk[63:32]  ^ n1;
        n3   = rk[31:0]   ^ n2;
        rk_n = {n0, n1, n2, n3};
        rnd_out = ((rnd == 4'd10) ? sr : mc) ^ rk_n;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        load_done  = 1'b0;
        last_round = 1'b0;
        case (state)
            LOAD: begin
                if (cnt == 7'd127) begin
                    state_nx  = INIT;
                    load_done = 1'b1;
                end
            end
            INIT:  state_nx = ROUND;
            ROUND: begin
                if (rnd == 4'd10) begin
                    state_nx   = LOAD;
                    last_round = 1'b1;
                end
            end
            default: state_nx = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt         <= 7'd0;
            rnd         <= 4'd0;
            first_block <= 1'b1;
            data_sr     <= '0;
            key_sr      <= '0;
            iv_sr       <= '0;
            st          <= '0;
            rk          <= '0;
            out         <= '0;
            flag_sinp   <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    data_sr <= {data_sr[126:0], s_inp};
                    if (first_block) begin
                        key_sr <= {key_sr[126:0], s_key};
                        iv_sr  <= {iv_sr[126:0], s_init_v};
                    end
                    if (load_done) begin
                        cnt       <= 7'd0;
                        flag_sinp <= 1'b1;
                    end else begin
                        cnt <= cnt + 7'd1;
                    end
                end
                INIT: begin
                    st  <= data_sr ^ iv_sr ^ key_sr;
                    rk  <= key_sr;
                    rnd <= 4'd1;
                end
                ROUND: begin
                    st  <= rnd_out;
                    rk  <= rk_n;
                    rnd <= rnd + 4'd1;
                    // The ciphertext becomes the chain value for the next block.
                    if (last_round) begin
                        out         <= rnd_out;
                        iv_sr       <= rnd_out;
                        flag_sinp   <= 1'b0;
                        first_block <= 1'b0;
                        cnt         <= 7'd0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_aes128_cbc.sv
// Bench for aes128_cbc: serial driver, byte-array AES reference model, and a
// monitor that pops expected ciphertexts on each falling edge of flag_sinp.
module tb_aes128_cbc;

    logic         clk;
    logic         rst_n;
    logic         s_inp;
    logic         s_key;
    logic         s_init_v;
    logic [127:0] out;
    logic         flag_sinp;

    aes128_cbc dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_inp     (s_inp),
        .s_key     (s_key),
        .s_init_v  (s_init_v),
        .out       (out),
        .flag_sinp (flag_sinp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [127:0] exp_q[$];
    logic [7:0]   sbox_t[256];

    logic         mon_en = 1'b0;
    logic         rst_at_edge = 1'b0;
    logic         prev_flag = 1'b0;
    logic [127:0] model_out = '0;
    int           hi_cnt = 0;

    logic         first_m;
    logic [127:0] key_m, chain_m;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic [7:0] y;
        p = 8'h00;
        x = a;
        y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? (({x[6:0], 1'b0}) ^ 8'h1b) : {x[6:0], 1'b0};
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box built by brute-force inverse search plus the bitwise affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c;
        c = 8'h63;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            for (int i = 0; i < 8; i++) begin
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8]
                     ^ inv[(i+7)%8] ^ c[i];
            end
            sbox_t[a] = s;
        end
    endtask

    function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
        logic [7:0]   s[16];
        logic [7:0]   t[16];
        logic [7:0]   w[176];
        logic [7:0]   tmp[4];
        logic [7:0]   rc;
        logic [127:0] res;
        for (int i = 0; i < 16; i++) begin
            w[i] = key[127-8*i -: 8];
            s[i] = pt[127-8*i -: 8];
        end
        rc = 8'h01;
        for (int i = 16; i < 176; i += 4) begin
            for (int j = 0; j < 4; j++) tmp[j] = w[i-4+j];
            if (i % 16 == 0) begin
                tmp[0] = sbox_t[w[i-3]] ^ rc;
                tmp[1] = sbox_t[w[i-2]];
                tmp[2] = sbox_t[w[i-1]];
                tmp[3] = sbox_t[w[i-4]];
                rc = gmul(rc, 8'h02);
            end
            for (int j = 0; j < 4; j++) w[i+j] = w[i-16+j] ^ tmp[j];
        end
        for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[i];
        for (int r = 1; r <= 10; r++) begin
            for (int i = 0; i < 16; i++) s[i] = sbox_t[s[i]];
            for (int c = 0; c < 4; c++)
                for (int q = 0; q < 4; q++) t[4*c+q] = s[4*((c+q)%4)+q];
            for (int c = 0; c < 4; c++) begin
                if (r < 10) begin
                    s[4*c+0] = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int q = 0; q < 4; q++) s[4*c+q] = t[4*c+q];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[16*r+i];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic drive_garbage();
        s_inp    = 1'($urandom);
        s_key    = 1'($urandom);
        s_init_v = 1'($urandom);
    endtask

    // Starts on a falling edge; returns on the falling edge after the 128th bit.
    task automatic send_block(input logic [127:0] data, input logic [127:0] key,
                              input logic [127:0] iv, input bit use_const,
                              input logic [127:0] const_ct);
        logic [127:0] e;
        if (first_m) begin
            key_m   = key;
            chain_m = iv;
            first_m = 1'b0;
        end
        e = use_const ? const_ct : aes_ref(key_m, data ^ chain_m);
        for (int i = 0; i < 128; i++) begin
            s_inp    = data[127-i];
            s_key    = key[127-i];
            s_init_v = iv[127-i];
            if (i == 127) exp_q.push_back(e);
            @(negedge clk);
            check($sformatf("flag_bit%0d", i + 1), {127'd0, flag_sinp}, {127'd0, (i == 127)});
        end
        chain_m = e;
    endtask

    task automatic wait_done();
        for (int n = 0; n < 20 && flag_sinp; n++) begin
            drive_garbage();
            @(negedge clk);
        end
        if (flag_sinp) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got flag_sinp=1 expected 0 within 20 cycles");
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_garbage();
        @(negedge clk);
        rst_n   = 1'b1;
        first_m = 1'b1;
    endtask

    always @(posedge clk) rst_at_edge <= !rst_n;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rst_at_edge) begin
                check("reset_out", out, 128'd0);
                check("reset_flag", {127'd0, flag_sinp}, 128'd0);
                exp_q.delete();
                model_out = '0;
                hi_cnt    = 0;
                prev_flag = 1'b0;
            end else begin
                if (prev_flag && !flag_sinp) begin
                    check("latency", 128'(hi_cnt), 128'd11);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_out: got %h expected no output", out);
                    end else begin
                        model_out = exp_q.pop_front();
                        check("ciphertext", out, model_out);
                    end
                    hi_cnt = 0;
                end else begin
                    if (flag_sinp) hi_cnt++;
                    check("out_hold", out, model_out);
                end
                prev_flag = flag_sinp;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish expected finish before 2ms");
        $fatal(1, "timeout");
    end

    localparam logic [127:0] KEY_C1 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C1  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] IV_S   = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P1_S   = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] C1_S   = 128'h7649abac8119b246cee98e9b12e9197d;
    localparam logic [127:0] P2_S   = 128'hae2d8a571e03ac9c9eb76fac45af8e51;
    localparam logic [127:0] C2_S   = 128'h5086cb9b507219ee95db113a917678b2;

    initial begin
        logic [127:0] rk;
        logic [127:0] riv;
        build_sbox();
        first_m  = 1'b1;
        rst_n    = 1'b0;
        s_inp    = 1'b0;
        s_key    = 1'b0;
        s_init_v = 1'b0;
        repeat (3) @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // FIPS-197 C.1, then a block of all-zero plaintext chained on it
        send_block(PT_C1, KEY_C1, 128'd0, 1'b1, CT_C1);
        wait_done();
        send_block(128'd0, rand128(), rand128(), 1'b0, 128'd0);
        wait_done();

        // FIPS-197 appendix B
        do_reset();
        send_block(PT_B, KEY_B, 128'd0, 1'b1, CT_B);
        wait_done();

        // SP800-38A CBC, two chained blocks with garbage key/IV on the second
        do_reset();
        send_block(P1_S, KEY_B, IV_S, 1'b1, C1_S);
        wait_done();
        send_block(P2_S, rand128(), rand128(), 1'b1, C2_S);
        wait_done();

        // Abort during round 5, then a fresh first block
        do_reset();
        send_block(PT_C1, KEY_C1, 128'd0, 1'b1, CT_C1);
        for (int k = 0; k < 5; k++) begin
            drive_garbage();
            @(negedge clk);
        end
        do_reset();
        send_block(PT_C1, KEY_C1, 128'd0, 1'b1, CT_C1);
        wait_done();

        // Abort during load at bit 60, then a full reload
        do_reset();
        for (int i = 0; i < 60; i++) begin
            s_inp    = PT_B[127-i];
            s_key    = KEY_B[127-i];
            s_init_v = 1'b0;
            @(negedge clk);
        end
        do_reset();
        send_block(PT_B, KEY_B, 128'd0, 1'b1, CT_B);
        wait_done();

        // Random sessions of chained blocks
        for (int sess = 0; sess < 4; sess++) begin
            do_reset();
            rk  = rand128();
            riv = rand128();
            for (int b = 0; b < 3; b++) begin
                send_block(rand128(), (b == 0) ? rk : rand128(),
                           (b == 0) ? riv : rand128(), 1'b0, 128'd0);
                wait_done();
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
